multi_timer_core: RTL and testbench

- N-channel stopwatch/countdown core; parametrised successor to the single-channel stopwatch/timer wrapper.
- Every channel counts independently from a shared tick enable.
- Front-panel commands (debounced single-cycle pulses) act only on the channel picked by ch_sel.
- The selected channel's MM:SS, an alarm blink and a lap-freeze view drive the existing display driver and blinking display.

---
 rtl/mtimer_pkg.sv | 22 ++
 rtl/mtimer_channel.sv | 143 ++++++++++++++
 rtl/multi_timer_core.sv | 133 +++++++++++++
 tb/tb_multi_timer_core.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared types for the multi-channel stopwatch/countdown core.
// Channel states, front-panel command bundle and seconds limit.
package mtimer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } ch_state_t;

  typedef struct packed {
    logic start;
    logic stop;
    logic softrst;
    logic inc_min;
    logic inc_sec;
  } cmd_t;

  localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/mtimer_channel.sv
// One timer channel: state, prescaler, MM:SS value and alarm counter.
// Commands arrive pre-prioritised and already steered to this channel.
module mtimer_channel
  import mtimer_pkg::*;
#(
  parameter int MIN_W         = 7,
  parameter int MAX_MIN       = 99,
  parameter int TICKS_PER_SEC = 1000,
  parameter int ALARM_SEC     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             sel_i,
  input  logic             mode_sw_i,
  input  cmd_t             cmd_i,
  output ch_state_t        state_o,
  output logic [MIN_W-1:0] min_o,
  output logic [5:0]       sec_o,
  output logic             phase_o
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [MIN_W-1:0] MM_LAST = MIN_W'(MAX_MIN);
  localparam logic [AW-1:0] AL_LAST = AW'(ALARM_SEC - 1);

  ch_state_t        st_q, st_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [AW-1:0]    alm_q, alm_d;

  logic          mode_eff;
  logic          step;
  logic [PW-1:0] psc_adv;

  assign mode_eff = (st_q == ST_IDLE && sel_i) ? mode_sw_i : mode_q;
  assign step     = tick_i && (psc_q == PS_LAST);
  assign psc_adv  = !tick_i ? psc_q :
                    step ? '0 : psc_q + PW'(1);

  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    psc_d  = psc_q;
    min_d  = min_q;
    sec_d  = sec_q;
    alm_d  = alm_q;
    if (st_q == ST_IDLE && sel_i) mode_d = mode_sw_i;
    if (cmd_i.softrst) begin
      st_d  = ST_IDLE;
      psc_d = '0;
      min_d = '0;
      sec_d = '0;
      alm_d = '0;
    end else begin
      case (st_q)
        ST_IDLE, ST_PAUSED: begin
          if (cmd_i.start) begin
            if (st_q == ST_PAUSED || !mode_eff ||
                min_q != '0 || sec_q != '0)
              st_d = ST_RUN;
          end else if (cmd_i.inc_min && mode_eff) begin
            min_d = (min_q == MM_LAST) ? '0 : min_q + MIN_W'(1);
          end else if (cmd_i.inc_sec && mode_eff) begin
            sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;
          end
        end
        ST_RUN: begin
          if (cmd_i.stop) begin
            st_d = ST_PAUSED;
          end else begin
            psc_d = psc_adv;
            if (step && !mode_q) begin
              if (sec_q != SEC_MAX) begin
                sec_d = sec_q + 6'd1;
              end else if (min_q != MM_LAST) begin
                sec_d = '0;
                min_d = min_q + MIN_W'(1);
              end
            end else if (step) begin
              // Reaching 00:00 expires on the same edge
              if (min_q == '0 && sec_q <= 6'd1) begin
                st_d  = ST_EXPIRED;
                sec_d = '0;
                alm_d = '0;
              end else if (sec_q == '0) begin
                sec_d = SEC_MAX;
                min_d = min_q - MIN_W'(1);
              end else begin
                sec_d = sec_q - 6'd1;
              end
            end
          end
        end
        ST_EXPIRED: begin
          if (cmd_i.start) begin
            st_d  = ST_IDLE;
            psc_d = '0;
            alm_d = '0;
          end else begin
            psc_d = psc_adv;
            if (step && alm_q == AL_LAST) begin
              st_d  = ST_IDLE;
              alm_d = '0;
            end else if (step) begin
              alm_d = alm_q + AW'(1);
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      mode_q <= 1'b0;
      psc_q  <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      alm_q  <= '0;
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      psc_q  <= psc_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      alm_q  <= alm_d;
    end
  end

  assign state_o = st_q;
  assign min_o   = min_q;
  assign sec_o   = sec_q;
  assign phase_o = (st_q == ST_EXPIRED) && (psc_q < PS_HALF);

endmodule

// File: rtl/multi_timer_core.sv
// N-channel stopwatch/countdown core: command steering, display mux,
// lap freeze and registered display outputs.
module multi_timer_core
  import mtimer_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int MIN_W         = 7,
  parameter int MAX_MIN       = 99,
  parameter int TICKS_PER_SEC = 1000,
  parameter int ALARM_SEC     = 10,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [CW-1:0]     ch_sel,
  input  logic              mode_sw,
  input  logic              start,
  input  logic              stop,
  input  logic              softrst,
  input  logic              inc_min,
  input  logic              inc_sec,
  input  logic              lap,
  output logic [MIN_W-1:0]  minutes,
  output logic [5:0]        seconds,
  output logic              blink,
  output logic              lap_active,
  output logic [NUM_CH-1:0] running_vec,
  output logic [NUM_CH-1:0] expired_vec
);

  cmd_t             pri;
  logic             sel_valid;
  ch_state_t        ch_st  [NUM_CH];
  logic [MIN_W-1:0] ch_min [NUM_CH];
  logic [5:0]       ch_sec [NUM_CH];
  logic             ch_ph  [NUM_CH];

  logic [MIN_W-1:0] live_min;
  logic [5:0]       live_sec;
  logic             live_alarm;

  logic             lap_q, lap_d;
  logic [CW-1:0]    snap_q, snap_d;
  logic [MIN_W-1:0] minutes_q;
  logic [5:0]       seconds_q;
  logic             blink_q;

  assign sel_valid = ({1'b0, ch_sel} < (CW + 1)'(NUM_CH));

  always_comb begin
    pri = '0;
    priority case (1'b1)
      softrst: pri.softrst = 1'b1;
      stop:    pri.stop    = 1'b1;
      start:   pri.start   = 1'b1;
      inc_min: pri.inc_min = 1'b1;
      inc_sec: pri.inc_sec = 1'b1;
      default: pri = '0;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel_g;
    assign sel_g = sel_valid && (ch_sel == CW'(g));

    mtimer_channel #(
      .MIN_W        (MIN_W),
      .MAX_MIN      (MAX_MIN),
      .TICKS_PER_SEC(TICKS_PER_SEC),
      .ALARM_SEC    (ALARM_SEC)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .sel_i    (sel_g),
      .mode_sw_i(mode_sw),
      .cmd_i    (sel_g ? pri : '0),
      .state_o  (ch_st[g]),
      .min_o    (ch_min[g]),
      .sec_o    (ch_sec[g]),
      .phase_o  (ch_ph[g])
    );

    assign running_vec[g] = (ch_st[g] == ST_RUN);
    assign expired_vec[g] = (ch_st[g] == ST_EXPIRED);
  end

  always_comb begin
    live_min   = '0;
    live_sec   = '0;
    live_alarm = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_valid && ch_sel == CW'(i)) begin
        live_min   = ch_min[i];
        live_sec   = ch_sec[i];
        live_alarm = ch_ph[i];
      end
    end
  end

  // Any softrst releases: either it hits the frozen channel or ch_sel moved
  always_comb begin
    snap_d = lap_q ? snap_q : ch_sel;
    if (softrst)    lap_d = 1'b0;
    else if (lap_q) lap_d = !(lap || ch_sel != snap_q);
    else            lap_d = lap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_q     <= 1'b0;
      snap_q    <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      lap_q   <= lap_d;
      snap_q  <= snap_d;
      blink_q <= live_alarm;
      if (!(lap_q && lap_d)) begin
        minutes_q <= live_min;
        seconds_q <= live_sec;
      end
    end
  end

  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign blink      = blink_q;
  assign lap_active = lap_q;

endmodule

// File: tb/tb_multi_timer_core.sv
// Directed bench for multi_timer_core with 2 channels and 4 ticks/s.
// Each scenario task checks its own hand-computed results inline.
module tb_multi_timer_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [0:0] ch_sel = 1'b0;
  logic       mode_sw = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       softrst = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_sec = 1'b0;
  logic       lap = 1'b0;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       blink;
  logic       lap_active;
  logic [1:0] running_vec;
  logic [1:0] expired_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_timer_core #(
    .NUM_CH       (2),
    .MIN_W        (7),
    .MAX_MIN      (99),
    .TICKS_PER_SEC(4),
    .ALARM_SEC    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .ch_sel     (ch_sel),
    .mode_sw    (mode_sw),
    .start      (start),
    .stop       (stop),
    .softrst    (softrst),
    .inc_min    (inc_min),
    .inc_sec    (inc_sec),
    .lap        (lap),
    .minutes    (minutes),
    .seconds    (seconds),
    .blink      (blink),
    .lap_active (lap_active),
    .running_vec(running_vec),
    .expired_vec(expired_vec)
  );

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press(input logic st, sp, sr, im, is, lp);
    start = st; stop = sp; softrst = sr;
    inc_min = im; inc_sec = is; lap = lp;
    @(negedge clk);
    start = 0; stop = 0; softrst = 0;
    inc_min = 0; inc_sec = 0; lap = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (minutes !== 7'd0 || seconds !== 6'd0) begin
      errors++;
      $display("FAIL reset_disp: got %0d:%0d want 0:0", minutes, seconds);
    end
    checks++;
    if (blink !== 1'b0 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: blink=%b lap=%b want 0 0", blink, lap_active);
    end
    checks++;
    if (running_vec !== 2'b00 || expired_vec !== 2'b00) begin
      errors++;
      $display("FAIL reset_vec: run=%b exp=%b want 00 00", running_vec, expired_vec);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stopwatch;
    ch_sel = 1'b0; mode_sw = 1'b0;
    @(negedge clk);
    press(1, 0, 0, 0, 0, 0);
    ticks(244);
    checks++;
    if (minutes !== 7'd1 || seconds !== 6'd1 || running_vec !== 2'b01) begin
      errors++;
      $display("FAIL sw_61s: got %0d:%0d run=%b want 1:1 run=01", minutes, seconds, running_vec);
    end
    press(0, 1, 0, 0, 0, 0);
    ticks(40);
    checks++;
    if (minutes !== 7'd1 || seconds !== 6'd1 || running_vec !== 2'b00) begin
      errors++;
      $display("FAIL sw_paused: got %0d:%0d run=%b want 1:1 run=00", minutes, seconds, running_vec);
    end
    press(1, 0, 0, 0, 0, 0);
    ticks(4);
    checks++;
    if (minutes !== 7'd1 || seconds !== 6'd2) begin
      errors++;
      $display("FAIL sw_resume: got %0d:%0d want 1:2", minutes, seconds);
    end
  endtask

  task automatic test_countdown;
    ch_sel = 1'b1; mode_sw = 1'b1;
    @(negedge clk);
    press(0, 0, 0, 1, 0, 0);
    press(0, 0, 0, 1, 0, 0);
    repeat (3) press(0, 0, 0, 0, 1, 0);
    checks++;
    if (minutes !== 7'd2 || seconds !== 6'd3) begin
      errors++;
      $display("FAIL cd_preset: got %0d:%0d want 2:3", minutes, seconds);
    end
    press(1, 0, 0, 0, 0, 0);
    ticks(492);
    checks++;
    if (expired_vec !== 2'b10 || running_vec !== 2'b01) begin
      errors++;
      $display("FAIL cd_expired: exp=%b run=%b want 10 01", expired_vec, running_vec);
    end
    checks++;
    if (minutes !== 7'd0 || seconds !== 6'd0 || blink !== 1'b1) begin
      errors++;
      $display("FAIL cd_zero: got %0d:%0d blink=%b want 0:0 blink=1", minutes, seconds, blink);
    end
    ticks(2);
    checks++;
    if (blink !== 1'b0) begin
      errors++;
      $display("FAIL cd_blink_lo: got %b want 0", blink);
    end
    ticks(2);
    checks++;
    if (blink !== 1'b1) begin
      errors++;
      $display("FAIL cd_blink_hi: got %b want 1", blink);
    end
    ticks(35);
    checks++;
    if (expired_vec !== 2'b10) begin
      errors++;
      $display("FAIL cd_alarm_39: exp=%b want 10", expired_vec);
    end
    ticks(1);
    checks++;
    if (expired_vec !== 2'b00 || blink !== 1'b0) begin
      errors++;
      $display("FAIL cd_auto_idle: exp=%b blink=%b want 00 0", expired_vec, blink);
    end
  endtask

  task automatic test_concurrency;
    ch_sel = 1'b1;
    @(negedge clk);
    press(0, 0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0, 0);
    checks++;
    if (running_vec !== 2'b01) begin
      errors++;
      $display("FAIL cd_zero_start: run=%b want 01", running_vec);
    end
    ticks(4);
    press(0, 1, 0, 0, 0, 0);
    ticks(4);
    ch_sel = 1'b0;
    @(negedge clk);
    checks++;
    if (minutes !== 7'd3 || seconds !== 6'd17 || running_vec !== 2'b01) begin
      errors++;
      $display("FAIL conc_ch0: got %0d:%0d run=%b want 3:17 run=01", minutes, seconds, running_vec);
    end
  endtask

  task automatic test_saturate;
    ch_sel = 1'b0; mode_sw = 1'b1;
    press(0, 0, 1, 0, 0, 0);
    repeat (99) press(0, 0, 0, 1, 0, 0);
    checks++;
    if (minutes !== 7'd99 || seconds !== 6'd0) begin
      errors++;
      $display("FAIL inc_min_99: got %0d:%0d want 99:0", minutes, seconds);
    end
    press(0, 0, 0, 1, 0, 0);
    checks++;
    if (minutes !== 7'd0) begin
      errors++;
      $display("FAIL inc_min_wrap: got %0d want 0", minutes);
    end
    repeat (99) press(0, 0, 0, 1, 0, 0);
    repeat (59) press(0, 0, 0, 0, 1, 0);
    checks++;
    if (minutes !== 7'd99 || seconds !== 6'd59) begin
      errors++;
      $display("FAIL inc_to_max: got %0d:%0d want 99:59", minutes, seconds);
    end
    press(0, 0, 0, 0, 1, 0);
    checks++;
    if (minutes !== 7'd99 || seconds !== 6'd0) begin
      errors++;
      $display("FAIL inc_sec_wrap: got %0d:%0d want 99:0", minutes, seconds);
    end
    repeat (59) press(0, 0, 0, 0, 1, 0);
    mode_sw = 1'b0;
    @(negedge clk);
    press(1, 0, 0, 0, 0, 0);
    ticks(8);
    checks++;
    if (minutes !== 7'd99 || seconds !== 6'd59 || running_vec !== 2'b01) begin
      errors++;
      $display("FAIL sw_saturate: got %0d:%0d run=%b want 99:59 run=01", minutes, seconds, running_vec);
    end
  endtask

  task automatic test_lap;
    press(0, 0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0, 0);
    ticks(20);
    press(0, 0, 0, 0, 0, 1);
    checks++;
    if (minutes !== 7'd0 || seconds !== 6'd5 || lap_active !== 1'b1) begin
      errors++;
      $display("FAIL lap_take: got %0d:%0d lap=%b want 0:5 lap=1", minutes, seconds, lap_active);
    end
    ticks(12);
    checks++;
    if (seconds !== 6'd5 || lap_active !== 1'b1) begin
      errors++;
      $display("FAIL lap_hold: got sec=%0d lap=%b want 5 lap=1", seconds, lap_active);
    end
    press(0, 0, 0, 0, 0, 1);
    checks++;
    if (minutes !== 7'd0 || seconds !== 6'd8 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL lap_release: got %0d:%0d lap=%b want 0:8 lap=0", minutes, seconds, lap_active);
    end
    press(0, 0, 0, 0, 0, 1);
    ch_sel = 1'b1;
    @(negedge clk);
    checks++;
    if (lap_active !== 1'b0 || seconds !== 6'd0) begin
      errors++;
      $display("FAIL lap_chsel: lap=%b sec=%0d want 0 0", lap_active, seconds);
    end
    ch_sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority;
    press(1, 1, 0, 0, 0, 0);
    checks++;
    if (running_vec !== 2'b00) begin
      errors++;
      $display("FAIL prio_stop: run=%b want 00", running_vec);
    end
    ticks(4);
    checks++;
    if (seconds !== 6'd8) begin
      errors++;
      $display("FAIL prio_frozen: sec=%0d want 8", seconds);
    end
    press(0, 0, 1, 0, 0, 1);
    checks++;
    if (minutes !== 7'd0 || seconds !== 6'd0 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL prio_softrst_lap: got %0d:%0d lap=%b want 0:0 lap=0", minutes, seconds, lap_active);
    end
  endtask

  initial begin
    test_reset();
    test_stopwatch();
    test_countdown();
    test_concurrency();
    test_saturate();
    test_lap();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
